// File: rtl/ic_q_pkg.sv
// rtl/ic_q_pkg.sv - shared constants and width helpers for the instruction-cache fetch queue
package ic_q_pkg;

    localparam logic INST_VALID = 1'b1;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ic_q_if.sv
// rtl/ic_q_if.sv - fetch-issue / memory-response / decode handshake bundle for ic_q
interface ic_q_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] PC_I;
    logic              IV_I;
    logic              REQ_RDY_O;
    logic [DATA_W-1:0] RDATA_I;
    logic              RVALID_I;
    logic              FLUSH_I;
    logic [ADDR_W-1:0] PC_O;
    logic [DATA_W-1:0] INST_O;
    logic              IV_O;
    logic              DS_RDY_I;
    logic              RSP_ERR_O;

    modport slave (
        input  PC_I, IV_I, RDATA_I, RVALID_I, FLUSH_I, DS_RDY_I,
        output REQ_RDY_O, PC_O, INST_O, IV_O, RSP_ERR_O
    );

    modport master (
        output PC_I, IV_I, RDATA_I, RVALID_I, FLUSH_I, DS_RDY_I,
        input  REQ_RDY_O, PC_O, INST_O, IV_O, RSP_ERR_O
    );
endinterface

// File: rtl/ic_q_buf.sv
// rtl/ic_q_buf.sv - DEPTH-entry {pc, inst, filled} array with tail write, fill and head read ports
module ic_q_buf
    import ic_q_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = ptr_w(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_clr,
    input  logic              i_wr_en,
    input  logic [PTR_W-1:0]  i_wr_ptr,
    input  logic [ADDR_W-1:0] i_wr_pc,
    input  logic              i_fill_en,
    input  logic [PTR_W-1:0]  i_fill_ptr,
    input  logic [DATA_W-1:0] i_fill_data,
    input  logic [PTR_W-1:0]  i_rd_ptr,
    output logic [ADDR_W-1:0] o_rd_pc,
    output logic [DATA_W-1:0] o_rd_inst,
    output logic              o_rd_filled
);
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
        logic              filled;
    } entry_t;

    entry_t r_mem [DEPTH];

    // A fill and a tail write never target the same slot (memory latency >= 1).
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_clr) begin
                for (int i = 0; i < DEPTH; i++) r_mem[i].filled <= 1'b0;
            end
            if (i_fill_en) begin
                r_mem[i_fill_ptr].inst   <= i_fill_data;
                r_mem[i_fill_ptr].filled <= INST_VALID;
            end
            if (i_wr_en) begin
                r_mem[i_wr_ptr].pc     <= i_wr_pc;
                r_mem[i_wr_ptr].inst   <= '0;
                r_mem[i_wr_ptr].filled <= 1'b0;
            end
        end
    end

    assign o_rd_pc     = r_mem[i_rd_ptr].pc;
    assign o_rd_inst   = r_mem[i_rd_ptr].inst;
    assign o_rd_filled = r_mem[i_rd_ptr].filled;
endmodule

// File: rtl/ic_q.sv
// rtl/ic_q.sv - in-order fetch queue between IF and ID with flush-drop accounting
module ic_q
    import ic_q_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input logic   CLK,
    input logic   RST,
    ic_q_if.slave bus
);
    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [PTR_W-1:0]  r_head, r_tail, r_fill;
    logic [CNT_W-1:0]  r_cnt, r_unf, r_drop;
    logic              r_err;

    logic [CNT_W:0]    w_occ;
    logic              w_rdy, w_push, w_pop, w_iv, w_has;
    logic              w_drop_rsp, w_fill, w_err_rsp, w_rsp_ok;
    logic [ADDR_W-1:0] w_rd_pc;
    logic [DATA_W-1:0] w_rd_inst;
    logic              w_rd_filled;

    assign w_occ  = {1'b0, r_cnt} + {1'b0, r_drop};
    assign w_rdy  = w_occ < (CNT_W+1)'(DEPTH);
    assign w_has  = (r_cnt != '0);
    assign w_iv   = w_has && w_rd_filled && !bus.FLUSH_I;
    assign w_push = bus.IV_I && w_rdy;
    assign w_pop  = w_iv && bus.DS_RDY_I;

    // Responses retire pending drops first, then the oldest unfilled entry.
    assign w_drop_rsp = bus.RVALID_I && (r_drop != '0);
    assign w_err_rsp  = bus.RVALID_I && (r_drop == '0) && (r_unf == '0);
    assign w_rsp_ok   = bus.RVALID_I && !w_err_rsp;
    assign w_fill     = bus.RVALID_I && (r_drop == '0) && (r_unf != '0) && !bus.FLUSH_I;

    ic_q_buf #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_buf (
        .CLK        (CLK),
        .RST        (RST),
        .i_clr      (bus.FLUSH_I),
        .i_wr_en    (w_push),
        .i_wr_ptr   (r_tail),
        .i_wr_pc    (bus.PC_I),
        .i_fill_en  (w_fill),
        .i_fill_ptr (r_fill),
        .i_fill_data(bus.RDATA_I),
        .i_rd_ptr   (r_head),
        .o_rd_pc    (w_rd_pc),
        .o_rd_inst  (w_rd_inst),
        .o_rd_filled(w_rd_filled)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_head <= '0;
            r_tail <= '0;
            r_fill <= '0;
            r_cnt  <= '0;
            r_unf  <= '0;
            r_drop <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_err_rsp) r_err <= 1'b1;
            if (bus.FLUSH_I) begin
                // Every unfilled entry becomes a drop; a same-cycle fetch survives as the new head.
                r_head <= r_tail;
                r_fill <= r_tail;
                r_tail <= r_tail + PTR_W'(w_push);
                r_cnt  <= CNT_W'(w_push);
                r_unf  <= CNT_W'(w_push);
                r_drop <= r_drop + r_unf - CNT_W'(w_rsp_ok);
            end else begin
                r_head <= r_head + PTR_W'(w_pop);
                r_tail <= r_tail + PTR_W'(w_push);
                r_fill <= r_fill + PTR_W'(w_fill);
                r_cnt  <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
                r_unf  <= r_unf + CNT_W'(w_push) - CNT_W'(w_fill);
                r_drop <= r_drop - CNT_W'(w_drop_rsp);
            end
        end
    end

    assign bus.REQ_RDY_O = w_rdy;
    assign bus.IV_O      = w_iv;
    assign bus.PC_O      = w_has ? w_rd_pc : '0;
    assign bus.INST_O    = w_has ? w_rd_inst : '0;
    assign bus.RSP_ERR_O = r_err;
endmodule

// File: tb/tb_ic_q.sv
// tb/tb_ic_q.sv - self-checking bench for ic_q: vector table, hand sequences and a queue scoreboard
module tb_ic_q;
    localparam int DEPTH = 4;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    ic_q_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ic_q #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        bit          killed;
    } out_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    out_t        mem_q[$];
    exp_t        exp_q[$];
    bit          m_err;
    bit          mon_en = 1'b0;
    bit          m_rdy, m_iv, m_found;
    logic [31:0] m_pc;
    out_t        m_o;

    // Scoreboard: outstanding fetches (killed ones become drops) and filled entries awaiting decode.
    always @(negedge CLK) begin
        if (!RST) begin
            mem_q.delete();
            exp_q.delete();
            m_err = 1'b0;
        end else if (mon_en) begin
            m_rdy = (mem_q.size() + exp_q.size()) < DEPTH;
            m_iv  = (exp_q.size() > 0) && !bus.FLUSH_I;
            check("sb_req_rdy", bus.REQ_RDY_O, m_rdy);
            check("sb_iv_o", bus.IV_O, m_iv);
            check("sb_rsp_err", bus.RSP_ERR_O, m_err);
            m_pc    = '0;
            m_found = 1'b0;
            if (exp_q.size() > 0) begin
                m_pc = exp_q[0].pc;
                check("sb_inst_o", bus.INST_O, exp_q[0].inst);
            end else begin
                foreach (mem_q[i]) begin
                    if (!m_found && !mem_q[i].killed) begin
                        m_pc    = mem_q[i].pc;
                        m_found = 1'b1;
                    end
                end
                if (!m_found) check("sb_inst_zero", bus.INST_O, 32'h0);
            end
            check("sb_pc_o", bus.PC_O, m_pc);

            if (!bus.FLUSH_I && m_iv && bus.DS_RDY_I) void'(exp_q.pop_front());
            if (bus.RVALID_I) begin
                if (mem_q.size() == 0) begin
                    m_err = 1'b1;
                end else begin
                    m_o = mem_q.pop_front();
                    if (!m_o.killed && !bus.FLUSH_I) exp_q.push_back('{m_o.pc, bus.RDATA_I});
                end
            end
            if (bus.FLUSH_I) begin
                exp_q.delete();
                foreach (mem_q[i]) mem_q[i].killed = 1'b1;
            end
            if (bus.IV_I && m_rdy) mem_q.push_back('{bus.PC_I, 1'b0});
        end
    end

    task automatic drive(input bit iv, input logic [31:0] pc, input bit rv, input logic [31:0] rd,
                         input bit fl, input bit ds);
        bus.IV_I     = iv;
        bus.PC_I     = pc;
        bus.RVALID_I = rv;
        bus.RDATA_I  = rd;
        bus.FLUSH_I  = fl;
        bus.DS_RDY_I = ds;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        bit          iv;
        logic [31:0] pc;
        bit          rv;
        logic [31:0] rd;
        bit          fl;
        bit          ds;
        bit          e_iv;
        logic [31:0] e_pc;
        bit          e_rdy;
    } vec_t;

    vec_t vecs[17];

    initial begin
        // Flush with three fetches outstanding: three drops, then the redirected fetch fills.
        vecs[0]  = '{1'b1, 32'h200, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h000, 1'b1};
        vecs[1]  = '{1'b1, 32'h204, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h200, 1'b1};
        vecs[2]  = '{1'b1, 32'h208, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h200, 1'b1};
        vecs[3]  = '{1'b1, 32'h400, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h200, 1'b1};
        vecs[4]  = '{1'b0, 32'h0,   1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h400, 1'b0};
        vecs[5]  = '{1'b0, 32'h0,   1'b1, 32'hAAAA_0000, 1'b0, 1'b1, 1'b0, 32'h400, 1'b0};
        vecs[6]  = '{1'b0, 32'h0,   1'b1, 32'hBBBB_0000, 1'b0, 1'b1, 1'b0, 32'h400, 1'b1};
        vecs[7]  = '{1'b0, 32'h0,   1'b1, 32'hCCCC_0000, 1'b0, 1'b1, 1'b0, 32'h400, 1'b1};
        vecs[8]  = '{1'b0, 32'h0,   1'b1, 32'h2402_0004, 1'b0, 1'b1, 1'b0, 32'h400, 1'b1};
        vecs[9]  = '{1'b0, 32'h0,   1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h400, 1'b1};
        vecs[10] = '{1'b0, 32'h0,   1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h000, 1'b1};
        // Flush with a filled head, two unfilled and a same-cycle response: one drop, head not popped.
        vecs[11] = '{1'b1, 32'h500, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h000, 1'b1};
        vecs[12] = '{1'b1, 32'h504, 1'b1, 32'h1111_0000, 1'b0, 1'b0, 1'b0, 32'h500, 1'b1};
        vecs[13] = '{1'b1, 32'h508, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h500, 1'b1};
        vecs[14] = '{1'b0, 32'h0,   1'b1, 32'h2222_0000, 1'b1, 1'b1, 1'b0, 32'h500, 1'b1};
        vecs[15] = '{1'b0, 32'h0,   1'b1, 32'h3333_0000, 1'b0, 1'b1, 1'b0, 32'h000, 1'b1};
        vecs[16] = '{1'b0, 32'h0,   1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h000, 1'b1};

        // Reset with random inputs.
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), $urandom, 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
            @(negedge CLK);
            check("rst_iv_o", bus.IV_O, 32'h0);
            check("rst_pc_o", bus.PC_O, 32'h0);
            check("rst_inst_o", bus.INST_O, 32'h0);
            check("rst_req_rdy", bus.REQ_RDY_O, 32'h1);
            check("rst_rsp_err", bus.RSP_ERR_O, 32'h0);
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 1);
        RST    = 1'b1;
        mon_en = 1'b1;
        next_cycle();

        // First fetch: response in cycle r, IV_O in r+1.
        drive(1, 32'h100, 0, 0, 0, 1);
        next_cycle();
        drive(0, 0, 1, 32'h2402_0001, 0, 1);
        @(negedge CLK);
        check("first_no_bypass", bus.IV_O, 32'h0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 1);
        @(negedge CLK);
        check("first_iv_o", bus.IV_O, 32'h1);
        check("first_pc_o", bus.PC_O, 32'h100);
        check("first_inst_o", bus.INST_O, 32'h2402_0001);
        next_cycle();
        next_cycle();

        // Streaming, latency 2: outputs on eight consecutive cycles.
        for (int k = 0; k < 12; k++) begin
            drive(k < 8, 32'h100 + 32'(4 * k), (k >= 2) && (k < 10), 32'h1000_0000 | 32'(k), 0, 1);
            @(negedge CLK);
            check("stream_iv_o", bus.IV_O, 32'((k >= 3) && (k <= 10)));
            check("stream_req_rdy", bus.REQ_RDY_O, 32'h1);
            next_cycle();
        end

        // Stall until full, then drain.
        for (int k = 0; k < 11; k++) begin
            drive(k < 4, 32'h100 + 32'(4 * k), (k >= 1) && (k <= 4), 32'h3000_0000 + 32'(k), 0, k >= 6);
            @(negedge CLK);
            if (k == 4 || k == 6) check("full_req_rdy_low", bus.REQ_RDY_O, 32'h0);
            if (k >= 4 && k <= 6) check("stall_head_pc", bus.PC_O, 32'h100);
            if (k == 7) check("full_req_rdy_back", bus.REQ_RDY_O, 32'h1);
            if (k == 7) check("drain_second_pc", bus.PC_O, 32'h104);
            next_cycle();
        end

        // Flush vector table.
        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].pc, vecs[i].rv, vecs[i].rd, vecs[i].fl, vecs[i].ds);
            @(negedge CLK);
            check($sformatf("vec%0d_iv_o", i), bus.IV_O, 32'(vecs[i].e_iv));
            check($sformatf("vec%0d_pc_o", i), bus.PC_O, vecs[i].e_pc);
            check($sformatf("vec%0d_req_rdy", i), bus.REQ_RDY_O, 32'(vecs[i].e_rdy));
            next_cycle();
        end
        check("flush_no_err", bus.RSP_ERR_O, 32'h0);

        // Stray response sets the sticky error and leaves the queue alone.
        drive(0, 0, 1, 32'hDEAD_BEEF, 0, 1);
        next_cycle();
        drive(1, 32'h700, 0, 0, 0, 1);
        @(negedge CLK);
        check("err_set", bus.RSP_ERR_O, 32'h1);
        check("err_queue_empty", bus.PC_O, 32'h0);
        next_cycle();
        drive(0, 0, 1, 32'h2402_0007, 0, 1);
        next_cycle();
        drive(1, 32'h800, 0, 0, 0, 1);
        @(negedge CLK);
        check("err_after_pc", bus.PC_O, 32'h700);
        check("err_sticky", bus.RSP_ERR_O, 32'h1);
        next_cycle();
        drive(0, 0, 0, 0, 1, 1);
        next_cycle();

        // Reset mid-operation clears pending drops and the error flag.
        drive(0, 0, 0, 0, 0, 1);
        RST = 1'b0;
        next_cycle();
        @(negedge CLK);
        check("rst2_err_clr", bus.RSP_ERR_O, 32'h0);
        check("rst2_req_rdy", bus.REQ_RDY_O, 32'h1);
        next_cycle();
        RST = 1'b1;
        drive(1, 32'h900, 0, 0, 0, 1);
        next_cycle();
        drive(0, 0, 1, 32'h2402_0009, 0, 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 1);
        @(negedge CLK);
        check("rst2_iv_o", bus.IV_O, 32'h1);
        check("rst2_pc_o", bus.PC_O, 32'h900);
        check("rst2_inst_o", bus.INST_O, 32'h2402_0009);
        next_cycle();
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
